// File: rtl/sdram_bist.sv
// Built-in self-test sequencer for sdram_module: two-pass address-derived pattern
// write/readback over [ADDR_FIRST, ADDR_LAST], with sticky pass/fail reporting.
module sdram_bist #(
  parameter logic [21:0] ADDR_FIRST = 22'd0,
  parameter logic [21:0] ADDR_LAST  = 22'd15,
  parameter logic [15:0] SEED       = 16'h1248
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        Start_Sig,
  input  logic        Busy_Sig,
  input  logic        Done_Sig,
  input  logic [15:0] RdData,
  output logic        WrEN_Sig,
  output logic        RdEN_Sig,
  output logic [21:0] BRC_Addr,
  output logic [15:0] WrData,
  output logic        Pass_Sig,
  output logic        Fail_Sig,
  output logic [7:0]  Err_Cnt,
  output logic [21:0] Fail_Addr,
  output logic [3:0]  LED
);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_WR, S_WGAP, S_RD, S_CHK} state_t;

  state_t      state, state_n;
  logic [21:0] addr, addr_n;
  logic        phase, phase_n;
  logic        wr_n, rd_n, pass_n, fail_n;
  logic [21:0] brc_n, faddr_n;
  logic [15:0] wdat_n;
  logic [7:0]  err_n;
  logic [3:0]  led_n;
  logic [15:0] pattern;
  logic        at_last;

  assign pattern = (addr[15:0] ^ SEED) ^ {16{phase}};
  assign at_last = (addr == ADDR_LAST);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= S_IDLE;
      addr      <= '0;
      phase     <= 1'b0;
      WrEN_Sig  <= 1'b0;
      RdEN_Sig  <= 1'b0;
      BRC_Addr  <= '0;
      WrData    <= '0;
      Pass_Sig  <= 1'b0;
      Fail_Sig  <= 1'b0;
      Err_Cnt   <= '0;
      Fail_Addr <= '0;
      LED       <= '0;
    end else begin
      state     <= state_n;
      addr      <= addr_n;
      phase     <= phase_n;
      WrEN_Sig  <= wr_n;
      RdEN_Sig  <= rd_n;
      BRC_Addr  <= brc_n;
      WrData    <= wdat_n;
      Pass_Sig  <= pass_n;
      Fail_Sig  <= fail_n;
      Err_Cnt   <= err_n;
      Fail_Addr <= faddr_n;
      LED       <= led_n;
    end
  end

  always_comb begin
    state_n = state;
    addr_n  = addr;
    phase_n = phase;
    wr_n    = WrEN_Sig;
    rd_n    = RdEN_Sig;
    brc_n   = BRC_Addr;
    wdat_n  = WrData;
    pass_n  = Pass_Sig;
    fail_n  = Fail_Sig;
    err_n   = Err_Cnt;
    faddr_n = Fail_Addr;
    case (state)
      S_IDLE: if (Start_Sig) begin
        err_n   = '0;
        faddr_n = '0;
        pass_n  = 1'b0;
        fail_n  = 1'b0;
        phase_n = 1'b0;
        state_n = S_INIT;
      end
      S_INIT: if (!Busy_Sig) begin
        addr_n  = ADDR_FIRST;
        state_n = S_WR;
      end
      // Entry cycle raises the request; Done only counts once it is up.
      S_WR: begin
        if (!WrEN_Sig) begin
          wr_n   = 1'b1;
          brc_n  = addr;
          wdat_n = pattern;
        end else if (Done_Sig) begin
          wr_n    = 1'b0;
          state_n = S_WGAP;
        end
      end
      S_WGAP: begin
        if (at_last) begin
          addr_n  = ADDR_FIRST;
          state_n = S_RD;
        end else begin
          addr_n  = addr + 22'd1;
          state_n = S_WR;
        end
      end
      S_RD: begin
        if (!RdEN_Sig) begin
          rd_n  = 1'b1;
          brc_n = addr;
        end else if (Done_Sig) begin
          rd_n    = 1'b0;
          state_n = S_CHK;
        end
      end
      S_CHK: begin
        if (RdData != pattern) begin
          if (!Fail_Sig) faddr_n = addr;
          fail_n = 1'b1;
          if (Err_Cnt != 8'hFF) err_n = Err_Cnt + 8'd1;
        end
        // End test precedes increment so a window ending at 22'h3FFFFF never wraps.
        if (!at_last) begin
          addr_n  = addr + 22'd1;
          state_n = S_RD;
        end else if (!phase) begin
          phase_n = 1'b1;
          addr_n  = ADDR_FIRST;
          state_n = S_WR;
        end else begin
          pass_n  = ~fail_n;
          phase_n = 1'b0;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
    led_n = {fail_n, pass_n, phase_n, state_n != S_IDLE};
  end

endmodule

// File: tb/tb_sdram_bist.sv
// Directed bench for sdram_bist: two instances (default window and a single
// top-of-space address) each driven by a 3-cycle-latency memory model.
`timescale 1ns/1ps
module tb_sdram_bist;

  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;

  int ntests = 0;
  int nfail  = 0;

  // instance 0: default window 0..15
  logic        start0, busy0, done_m0, done_f0, Done0;
  logic [15:0] rdat0, wdat0;
  logic        wr0, rd0, pass0, fail0;
  logic [21:0] addr0, faddr0;
  logic [7:0]  err0;
  logic [3:0]  led0;
  assign Done0 = done_m0 | done_f0;

  sdram_bist u0 (
    .CLK(CLK), .RSTn(RSTn), .Start_Sig(start0), .Busy_Sig(busy0), .Done_Sig(Done0),
    .RdData(rdat0), .WrEN_Sig(wr0), .RdEN_Sig(rd0), .BRC_Addr(addr0), .WrData(wdat0),
    .Pass_Sig(pass0), .Fail_Sig(fail0), .Err_Cnt(err0), .Fail_Addr(faddr0), .LED(led0)
  );

  // instance 1: single address at the top of the space, memory always miscompares
  logic        start1, busy1, done1;
  logic [15:0] rdat1, wdat1;
  logic        wr1, rd1, pass1, fail1;
  logic [21:0] addr1, faddr1;
  logic [7:0]  err1;
  logic [3:0]  led1;
  assign busy1 = 1'b0;
  assign rdat1 = 16'hAAAA;

  sdram_bist #(.ADDR_FIRST(22'h3FFFFF), .ADDR_LAST(22'h3FFFFF), .SEED(16'h1248)) u1 (
    .CLK(CLK), .RSTn(RSTn), .Start_Sig(start1), .Busy_Sig(busy1), .Done_Sig(done1),
    .RdData(rdat1), .WrEN_Sig(wr1), .RdEN_Sig(rd1), .BRC_Addr(addr1), .WrData(wdat1),
    .Pass_Sig(pass1), .Fail_Sig(fail1), .Err_Cnt(err1), .Fail_Addr(faddr1), .LED(led1)
  );

  // memory model 0: Done three cycles after the request is seen
  logic [15:0] mem0 [0:15];
  logic        act0;
  int          cnt0;
  bit          stuck5 = 1'b0;
  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      act0 <= 1'b0; cnt0 <= 0; done_m0 <= 1'b0; rdat0 <= '0;
    end else begin
      done_m0 <= 1'b0;
      if (!act0 && !done_m0 && (wr0 || rd0)) begin
        act0 <= 1'b1; cnt0 <= 1;
      end else if (act0) begin
        if (cnt0 == 2) begin
          act0 <= 1'b0; done_m0 <= 1'b1;
          if (wr0) mem0[addr0[3:0]] <= wdat0;
          else rdat0 <= (stuck5 && addr0 == 22'd5) ? (mem0[addr0[3:0]] & 16'hFFFE)
                                                  : mem0[addr0[3:0]];
        end else cnt0 <= cnt0 + 1;
      end
    end
  end

  // memory model 1
  logic act1;
  int   cnt1;
  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      act1 <= 1'b0; cnt1 <= 0; done1 <= 1'b0;
    end else begin
      done1 <= 1'b0;
      if (!act1 && !done1 && (wr1 || rd1)) begin
        act1 <= 1'b1; cnt1 <= 1;
      end else if (act1) begin
        if (cnt1 == 2) begin act1 <= 1'b0; done1 <= 1'b1; end
        else cnt1 <= cnt1 + 1;
      end
    end
  end

  // protocol monitors, sampled on the falling edge
  logic [21:0] wa_log [0:1023];
  logic [15:0] wd_log [0:1023];
  int nwr0 = 0, nrd0 = 0, nwr1 = 0, nrd1 = 0;
  int ovl_err = 0, gap_err = 0, hold_err = 0, busy_err = 0, bad_addr1 = 0;
  logic pw0 = 0, pr0 = 0, pw1 = 0, pr1 = 0;
  logic [21:0] pa0 = '0;
  logic [15:0] pd0 = '0;
  always @(negedge CLK) begin
    if ((wr0 && rd0) || (wr1 && rd1)) ovl_err <= ovl_err + 1;
    if ((wr0 && pr0) || (rd0 && pw0)) gap_err <= gap_err + 1;
    if (((pw0 && wr0) || (pr0 && rd0)) && (addr0 != pa0 || wdat0 != pd0)) hold_err <= hold_err + 1;
    if (busy0 && (wr0 || rd0)) busy_err <= busy_err + 1;
    if (wr0 && !pw0) begin
      wa_log[nwr0] <= addr0; wd_log[nwr0] <= wdat0; nwr0 <= nwr0 + 1;
    end
    if (rd0 && !pr0) nrd0 <= nrd0 + 1;
    if (wr1 && !pw1) nwr1 <= nwr1 + 1;
    if (rd1 && !pr1) nrd1 <= nrd1 + 1;
    if ((wr1 || rd1) && addr1 != 22'h3FFFFF) bad_addr1 <= bad_addr1 + 1;
    pw0 <= wr0; pr0 <= rd0; pa0 <= addr0; pd0 <= wdat0;
    pw1 <= wr1; pr1 <= rd1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse0();
    @(negedge CLK) start0 = 1'b1;
    @(negedge CLK) start0 = 1'b0;
  endtask

  task automatic wait0(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if (!led0[0]) begin ok = 1'b1; break; end
    end
  endtask

  initial begin
    bit ok;
    int bw, br;
    start0 = 0; busy0 = 0; done_f0 = 0; start1 = 0;
    repeat (3) @(negedge CLK);
    chk("rst_u0_outs", {wr0, rd0, pass0, fail0, led0, err0}, 32'h0);
    chk("rst_u0_addr", {addr0, wdat0[9:0]}, 32'h0);
    chk("rst_u0_faddr", faddr0, 32'h0);
    chk("rst_u1_outs", {wr1, rd1, pass1, fail1, led1, err1}, 32'h0);
    RSTn = 1'b1;

    // clean run over 0..15
    bw = nwr0; br = nrd0;
    pulse0(); wait0(ok);
    chk("t1_finished", ok, 1);
    chk("t1_writes", nwr0 - bw, 32);
    chk("t1_reads", nrd0 - br, 32);
    chk("t1_a3_p0_addr", wa_log[bw + 3], 3);
    chk("t1_a3_p0_data", wd_log[bw + 3], 16'h124B);
    chk("t1_a3_p1_data", wd_log[bw + 19], 16'hEDB4);
    chk("t1_pass", pass0, 1);
    chk("t1_fail", fail0, 0);
    chk("t1_err", err0, 0);
    chk("t1_led", led0, 4'b0100);

    // stray Done while idle
    bw = nwr0; br = nrd0;
    @(negedge CLK) done_f0 = 1'b1;
    @(negedge CLK) done_f0 = 1'b0;
    repeat (5) @(negedge CLK);
    chk("idle_done_led", led0, 4'b0100);
    chk("idle_done_reqs", (nwr0 - bw) + (nrd0 - br), 0);

    // start re-pulsed mid-test
    bw = nwr0; br = nrd0;
    pulse0();
    repeat (50) @(negedge CLK);
    pulse0(); wait0(ok);
    chk("restart_finished", ok, 1);
    chk("restart_writes", nwr0 - bw, 32);
    chk("restart_reads", nrd0 - br, 32);
    chk("restart_pass", pass0, 1);

    // bit 0 stuck low at address 5
    stuck5 = 1'b1;
    pulse0(); wait0(ok);
    stuck5 = 1'b0;
    chk("stuck_finished", ok, 1);
    chk("stuck_fail", fail0, 1);
    chk("stuck_pass", pass0, 0);
    chk("stuck_faddr", faddr0, 5);
    chk("stuck_err", err0, 1);
    chk("stuck_led", led0, 4'b1000);

    // Busy held high after start
    busy0 = 1'b1;
    bw = nwr0;
    pulse0();
    repeat (100) @(negedge CLK);
    chk("busy_no_req", nwr0 - bw, 0);
    busy0 = 1'b0;
    wait0(ok);
    chk("busy_finished", ok, 1);
    chk("busy_first_addr", wa_log[bw], 0);
    chk("busy_first_data", wd_log[bw], 16'h1248);
    chk("busy_pass", pass0, 1);

    // reset while a read is outstanding
    pulse0();
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if (rd0) begin ok = 1'b1; break; end
    end
    chk("rst_saw_read", ok, 1);
    RSTn = 1'b0;
    #1;
    chk("midrst_reqs", {wr0, rd0}, 0);
    chk("midrst_outs", {pass0, fail0, led0, err0}, 0);
    chk("midrst_addr_data", {addr0[15:0], wdat0}, 0);
    chk("midrst_faddr", faddr0, 0);
    @(negedge CLK) RSTn = 1'b1;
    bw = nwr0; br = nrd0;
    pulse0(); wait0(ok);
    chk("postrst_finished", ok, 1);
    chk("postrst_first_addr", wa_log[bw], 0);
    chk("postrst_writes", nwr0 - bw, 32);
    chk("postrst_reads", nrd0 - br, 32);
    chk("postrst_pass", pass0, 1);

    // single address at 22'h3FFFFF, every read miscompares
    @(negedge CLK) start1 = 1'b1;
    @(negedge CLK) start1 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge CLK);
      if (!led1[0]) begin ok = 1'b1; break; end
    end
    chk("top_finished", ok, 1);
    chk("top_writes", nwr1, 2);
    chk("top_reads", nrd1, 2);
    chk("top_no_wrap", bad_addr1, 0);
    chk("top_err", err1, 2);
    chk("top_faddr", faddr1, 22'h3FFFFF);
    chk("top_flags", {fail1, pass1}, 2'b10);

    chk("no_overlap", ovl_err, 0);
    chk("gap_between_reqs", gap_err, 0);
    chk("addr_data_held", hold_err, 0);
    chk("no_req_while_busy", busy_err, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
